frame_derandomizer: RTL
=======================

// Module: frame_derandomizer
// PURPOSE
//  Receive-side counterpart of the PRBS15 (x^15+x^14+1) bit randomizer: removes the scrambling from a serial bitstream.
//  Frame-oriented: seed reloaded at every start-of-frame, fixed-length frames counted, valid/ready on both sides.
//  Sits between the demodulator bit slicer and the FEC decoder input.
// PARAMETERS
//  FRAME_BITS  64             bits per frame (>=2); frame ends after this many accepted bits
//  CNT_W       $clog2(FRAME_BITS+1)  bit-counter width (derived, do not override)
// PORTS
//  clk          in   1   single clock, all logic on rising edge
//  reset        in   1   synchronous, active-low reset
//  seed_in      in   15  frame seed; sampled when seed_load=1
//  seed_load    in   1   capture seed_in into seed register (any state)
//  in_valid     in   1   in_bit/in_sof valid
//  in_ready     out  1   block accepts input this cycle
//  in_bit       in   1   scrambled bit
//  in_sof       in   1   qualifies in_bit as first bit of a frame
//  out_valid    out  1   out_bit valid
//  out_ready    in   1   downstream accepts out_bit
//  out_bit      out  1   descrambled bit
//  out_eof      out  1   qualifies out_bit as last bit of frame
//  sof_err      out  1   one-cycle pulse: input dropped (no sof in IDLE) or frame aborted by early sof
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE, lfsr=0, seed=15'h4A80, bit_cnt=0, out_valid=0, out_bit=0, out_eof=0, sof_err=0.
//  Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready. in_ready = !out_valid | out_ready.
//  LFSR step per accepted bit: out = in_bit ^ lfsr[14]; then lfsr[14] <= lfsr[0]^lfsr[1], lfsr[13:0] <= lfsr[14:1].
//  Accepted bit with in_sof=1: uses seed (not lfsr) for this bit: out = in_bit ^ seed[14]; lfsr <= step(seed).
//  Latency: out_bit registered, appears the cycle after acceptance; full throughput 1 bit/clk when out_ready=1.
//  FSM: IDLE -> RUN on accepted bit with in_sof=1; bit_cnt <= 1.
//   RUN: accepted bit without sof: bit_cnt++; when this is bit FRAME_BITS: out_eof=1 on that output, -> IDLE, bit_cnt=0.
//   RUN: accepted bit with in_sof=1: sof_err pulse, old frame abandoned (no eof issued), new frame started as from IDLE.
//   IDLE: accepted bit without sof: bit dropped (no output), sof_err pulse, stay IDLE.
//   FRAME_BITS-th bit with in_sof=1 is treated as new-frame start (abort rule), not as end.
//  Output hold: while out_valid & !out_ready, out_bit/out_eof stable, in_ready=0, lfsr/bit_cnt frozen.
//  seed_load same cycle as sof acceptance: sof uses OLD seed; new seed applies to next frame.
//  seed_load never disturbs a frame in progress (lfsr untouched).
//  Reset mid-frame: everything to reset values; pending output discarded; next frame needs fresh sof.
//  sof_err and out_eof never X; sof_err is a registered one-cycle pulse.
// STRUCTURE
//  Package prbs15_pkg: LFSR_W=15, TAP_A=0, TAP_B=1, DEFAULT_SEED=15'h4A80, typedef lfsr_t [14:0], function prbs15_step(lfsr_t).
//  Randomizer side must import the same package so both ends share taps and default seed.
//  One sub-module: prbs15_lfsr (load, load_val, step enable, state out); FSM, counter and output register in top.
// TESTING
//  1 Seed 15'h4A80, sof on first bit, in_bit=0 for 15 bits, out_ready=1 -> out_bit = 1,0,0,0,0,0,0,1,1,1,1,1,1,0,1.
//  2 Round trip: reference PRBS15 randomizer (same seed) feeding 3 back-to-back 64-bit random frames
//    -> output equals original payload bit-for-bit; out_eof exactly on bits 64,128,192.
//  3 Backpressure: out_ready random 50% -> in_ready = !out_valid|out_ready every cycle; data identical to test 2.
//  4 in_valid bits with in_sof=0 while IDLE -> no out_valid, one sof_err pulse per bit, state stays IDLE.
//  5 sof at bit 20 of a frame -> sof_err pulse; new frame descrambled from seed; no out_eof for aborted frame.
//  6 reset=0 for one cycle at bit 30, then new sof frame -> outputs at reset values, then correct frame from default seed.
//  7 seed_load with new seed coincident with sof -> current frame uses old seed, following frame uses new seed.

Source files
------------

// File: rtl/prbs15_pkg.sv
// Shared PRBS15 (x^15 + x^14 + 1) definitions for the randomizer and derandomizer.
// Latency: n/a (types, constants and a combinational step function only).
// Backpressure: n/a.
// Contents: LFSR width, feedback taps, default frame seed, lfsr_t, FSM state type,
//           and prbs15_step(), the single-bit advance used by both link ends.
package prbs15_pkg;

    localparam int LFSR_W = 15;
    localparam int TAP_A  = 0;
    localparam int TAP_B  = 1;

    typedef logic [LFSR_W-1:0] lfsr_t;

    localparam lfsr_t DEFAULT_SEED = 15'h4A80;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } derand_state_t;

    // Key bit is always lfsr[14]; the register shifts toward bit 0 and the
    // feedback enters at the top.
    function automatic lfsr_t prbs15_step(input lfsr_t s);
        return {s[TAP_A] ^ s[TAP_B], s[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/prbs15_lfsr.sv
// PRBS15 keystream register: parallel load or single-step advance.
// Latency: state_o updates one cycle after load_i/step_i.
// Backpressure: none; holds its value whenever neither load_i nor step_i is set.
// Ports: clk, reset (sync, active-low), load_i/load_val_i (load wins over step),
//        step_i (advance one bit), state_o (current register contents).
module prbs15_lfsr
    import prbs15_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  load_i,
    input  lfsr_t load_val_i,
    input  logic  step_i,
    output lfsr_t state_o
);

    lfsr_t lfsr_q;
    lfsr_t lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = load_val_i;
        end else if (step_i) begin
            lfsr_d = prbs15_step(lfsr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/frame_derandomizer.sv
// Frame-oriented PRBS15 bit derandomizer; keystream reseeded at every start-of-frame.
// Latency: 1 cycle from accepted input bit to registered output bit; 1 bit/clk throughput.
// Backpressure: in_ready = !out_valid | out_ready; a stalled output freezes lfsr and counter.
// Ports: clk, reset (sync, active-low); seed_in/seed_load (next-frame seed);
//        in_valid/in_ready/in_bit/in_sof (scrambled stream);
//        out_valid/out_ready/out_bit/out_eof (clear stream); sof_err (framing error pulse).
module frame_derandomizer
    import prbs15_pkg::*;
#(
    parameter int FRAME_BITS = 64,
    parameter int CNT_W      = $clog2(FRAME_BITS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              seed_load,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_bit,
    input  logic              in_sof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bit,
    output logic              out_eof,
    output logic              sof_err
);

    derand_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    lfsr_t            seed_q, seed_d;
    logic             out_valid_q, out_valid_d;
    logic             out_bit_q, out_bit_d;
    logic             out_eof_q, out_eof_d;
    logic             sof_err_q, sof_err_d;

    lfsr_t            lfsr_state;
    logic             lfsr_load;
    logic             lfsr_step;
    logic             accept;
    logic [CNT_W-1:0] cnt_inc;

    prbs15_lfsr u_lfsr (
        .clk        (clk),
        .reset      (reset),
        .load_i     (lfsr_load),
        .load_val_i (prbs15_step(seed_q)),
        .step_i     (lfsr_step),
        .state_o    (lfsr_state)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign cnt_inc  = cnt_q + CNT_W'(1);

    // A new seed only takes effect at the next sof: seed_q feeds the LFSR
    // solely on sof acceptance, and an sof in the same cycle still sees the
    // registered (old) value.
    always_comb begin
        seed_d = seed_q;
        if (seed_load) begin
            seed_d = seed_in;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q && !out_ready;
        out_bit_d   = out_bit_q;
        out_eof_d   = out_eof_q;
        sof_err_d   = 1'b0;
        lfsr_load   = 1'b0;
        lfsr_step   = 1'b0;

        if (accept) begin
            if (in_sof) begin
                // sof always starts a frame; mid-frame it also abandons the
                // current one without an eof. FRAME_BITS >= 2, so a sof bit
                // can never also be the last bit.
                sof_err_d   = (state_q == ST_RUN);
                state_d     = ST_RUN;
                cnt_d       = CNT_W'(1);
                out_valid_d = 1'b1;
                out_bit_d   = in_bit ^ seed_q[LFSR_W-1];
                out_eof_d   = 1'b0;
                lfsr_load   = 1'b1;
            end else if (state_q == ST_RUN) begin
                out_valid_d = 1'b1;
                out_bit_d   = in_bit ^ lfsr_state[LFSR_W-1];
                lfsr_step   = 1'b1;
                if (cnt_inc == CNT_W'(FRAME_BITS)) begin
                    out_eof_d = 1'b1;
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                end else begin
                    out_eof_d = 1'b0;
                    cnt_d     = cnt_inc;
                end
            end else begin
                // Unframed bit while idle: dropped, flagged.
                sof_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            seed_q      <= DEFAULT_SEED;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            sof_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seed_q      <= seed_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_eof_q   <= out_eof_d;
            sof_err_q   <= sof_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_eof   = out_eof_q;
    assign sof_err   = sof_err_q;

endmodule
